// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the sequential divider: FSM state
// encoding, ALU opcode for DIV and the fixed divide latency.
package cpu_pkg;

    localparam int         DIV_WIDTH   = 32;
    localparam int         DIV_LATENCY = DIV_WIDTH + 3;
    localparam logic [4:0] ALU_DIV     = 5'b01101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    // Edge count from start sample to the done cycle for a given operand width.
    function automatic int div_latency(input int width);
        return width + 3;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on magnitudes: shifts the next dividend
// bit into the partial remainder and subtracts the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, bit_in};
    // rem_in < divisor keeps the difference inside WIDTH+1 bits, so the MSB is the borrow.
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Signed sequential divider, one quotient bit per cycle, fixed WIDTH+3 latency.
// result = {remainder, quotient}, consumed unmodified by the ALU DIV path.
module seq_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_cap, b_cap;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic             q_neg, r_neg, dz;
    logic             cap_en;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_fix, r_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (quo[WIDTH-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PREP;
            PREP:    state_nxt = ITER;
            ITER:    if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? PREP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state == PREP) || (state == ITER) || (state == FIX);
    assign done   = (state == DONE);
    assign cap_en = start && ((state == IDLE) || (state == DONE));

    // Divide-by-zero forces an all-ones quotient; the magnitude loop already
    // leaves |dividend| in the remainder, so the sign fix restores the dividend.
    assign q_fix = dz ? {WIDTH{1'b1}} : (q_neg ? -quo : quo);
    assign r_fix = r_neg ? -rem : rem;

    always_ff @(posedge clock) begin
        if (clear) begin
            a_cap       <= '0;
            b_cap       <= '0;
            quo         <= '0;
            rem         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (cap_en) begin
                a_cap <= dividend;
                b_cap <= divisor;
            end
            case (state)
                PREP: begin
                    quo   <= mag(a_cap);
                    dvs   <= mag(b_cap);
                    rem   <= '0;
                    cnt   <= '0;
                    q_neg <= a_cap[WIDTH-1] ^ b_cap[WIDTH-1];
                    r_neg <= a_cap[WIDTH-1];
                    dz    <= (b_cap == '0);
                end
                ITER: begin
                    rem <= step_rem;
                    quo <= {quo[WIDTH-2:0], step_q};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    result      <= {r_fix, q_fix};
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operands compared against an arithmetic reference model.
module tb_seq_divider;

    localparam int W   = 32;
    localparam int LAT = 35;

    logic            clock = 1'b0;
    logic            clear, start;
    logic [W-1:0]    dividend, divisor;
    logic            busy, done, div_by_zero;
    logic [2*W-1:0]  result;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    // {div_by_zero, remainder, quotient} from plain signed arithmetic.
    function automatic logic [2*W:0] ref_div(input logic signed [W-1:0] a,
                                             input logic signed [W-1:0] b);
        logic signed [W-1:0] q, r;
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        if (a == {1'b1, {(W-1){1'b0}}} && b == -1) return {1'b0, {W{1'b0}}, a};
        q = a / b;
        r = a % b;
        return {1'b0, r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // c = negedge index (after the start edge) where done was seen; 0 on timeout.
    task automatic wait_done(input int from, output int c);
        c = 0;
        for (int i = from + 1; i <= 60; i++) begin
            @(negedge clock);
            if (i == 2) check("busy_run", busy, 1);
            if (done === 1'b1) begin
                c = i;
                break;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int c);
        logic [2*W:0] e;
        e = ref_div(a, b);
        check({tag, "_lat"},    c, LAT);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_result"}, result, e[2*W-1:0]);
        check({tag, "_dz"},     div_by_zero, e[2*W]);
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int c;
        launch(a, b);
        wait_done(0, c);
        check_op(tag, a, b, c);
        @(negedge clock);
        check({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int c, ndone;
        logic [W-1:0] a, b;
        logic [2*W:0] e;

        clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        check("rst_busy",   busy, 0);
        check("rst_done",   done, 0);
        check("rst_result", result, 0);
        check("rst_dz",     div_by_zero, 0);

        run("p100_7",  32'd100, 32'd7);
        check("p100_7_const", result, 64'h00000002_0000000E);
        run("n100_7",  -32'sd100, 32'd7);
        check("n100_7_const", result, 64'hFFFFFFFE_FFFFFFF2);
        run("p100_n7", 32'd100, -32'sd7);
        check("p100_n7_const", result, 64'h00000002_FFFFFFF2);
        run("div0",    32'd5, 32'd0);
        check("div0_const", {result, 7'd0, div_by_zero}, {64'h00000005_FFFFFFFF, 8'd1});
        run("min_m1",  32'h80000000, 32'hFFFFFFFF);
        check("min_m1_const", result, 64'h00000000_80000000);
        run("negdiv0", 32'hFFFFFF00, 32'd0);

        // Clear mid-iteration aborts the division; result must hold until then.
        e = ref_div(32'hFFFFFF00, 32'd0);
        launch(32'd12345, 32'd11);
        repeat (9) @(negedge clock);
        check("hold_result", result, e[2*W-1:0]);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        check("clr_busy",   busy, 0);
        check("clr_result", result, 0);
        check("clr_dz",     div_by_zero, 0);
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        check("clr_no_done", ndone, 0);

        // Start while busy is ignored; start in the DONE cycle chains a new division.
        launch(32'd20, 32'd6);
        repeat (5) @(negedge clock);
        dividend = 32'd77; divisor = 32'd2; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(5, c);
        check_op("ignored", 32'd20, 32'd6, c);
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(0, c);
        check_op("chain", 32'd9, 32'd3, c);
        check("chain_const", result, 64'h00000000_00000003);

        for (int k = 0; k < 16; k++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if (k == 7) a = 32'h80000000;
            run($sformatf("rnd%0d", k), a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
